// File: rtl/mixer_sched_pkg.sv
// rtl/mixer_sched_pkg.sv - shared state types and saturating add for mixer_frame_scheduler
package mixer_sched_pkg;

  // Frame-level scheduler states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MIX,
    SEND_L,
    SEND_R
  } sched_state_t;

  // Per-channel progress through one left/right pair during FETCH.
  typedef enum logic [1:0] {
    AWAIT_L,
    AWAIT_R,
    DONE
  } fetch_phase_t;

  // Signed add of two sign-extended samples, clamped to a signed range of
  // 'width' bits (width <= 32). The result is returned sign-extended to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int width);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'($signed(a)) + longint'($signed(b));
    hi  = (longint'(1) <<< (width - 1)) - longint'(1);
    lo  = -(longint'(1) <<< (width - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/mixer_sched_chan_rx.sv
// rtl/mixer_sched_chan_rx.sv - per-channel pair capture, realignment and underrun count (MIXER_SCHED_HOLD_LAST_EN)
module mixer_sched_chan_rx
  import mixer_sched_pkg::*;
#(
  parameter int AUDIO_WIDTH = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   en_in,
  input  logic                   fetch,
  input  logic                   close,
  input  logic                   s_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   done_next,
  output logic [AUDIO_WIDTH-1:0] left,
  output logic [AUDIO_WIDTH-1:0] right,
  output logic [CNT_WIDTH-1:0]   underrun_cnt
);

  logic                   enabled;
  fetch_phase_t           phase;
  logic [AUDIO_WIDTH-1:0] cap_l;
  logic [AUDIO_WIDTH-1:0] cap_r;
  logic [AUDIO_WIDTH-1:0] sample;
  logic [AUDIO_WIDTH-1:0] sub_l;
  logic [AUDIO_WIDTH-1:0] sub_r;
  logic                   beat;
  logic                   pair_complete;
  logic                   underrun;
  logic                   unused_tdata;

  // LSBs below the MSB-aligned sample carry nothing.
  assign sample       = s_tdata[DATA_WIDTH-1 -: AUDIO_WIDTH];
  assign unused_tdata = ^s_tdata;

  assign s_tready      = fetch && enabled && (phase != DONE);
  assign beat          = s_tready && s_tvalid;
  assign pair_complete = beat && (phase == AWAIT_R) && s_tlast;
  // A disabled channel never holds up the frame.
  assign done_next     = !enabled || (phase == DONE) || pair_complete;
  assign underrun      = close && !done_next;

  assign left  = enabled ? cap_l : '0;
  assign right = enabled ? cap_r : '0;

`ifdef MIXER_SCHED_HOLD_LAST_EN
  logic [AUDIO_WIDTH-1:0] good_l;
  logic [AUDIO_WIDTH-1:0] good_r;

  // Remember the most recent complete pair as the underrun substitute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_l <= '0;
      good_r <= '0;
    end else if (pair_complete) begin
      good_l <= cap_l;
      good_r <= sample;
    end
  end

  assign sub_l = good_l;
  assign sub_r = good_r;
`else
  assign sub_l = '0;
  assign sub_r = '0;
`endif

  // Pair capture with realignment; an underrun overwrites any partial pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enabled <= 1'b0;
      phase   <= AWAIT_L;
      cap_l   <= '0;
      cap_r   <= '0;
    end else if (start) begin
      enabled <= en_in;
      phase   <= AWAIT_L;
    end else begin
      if (beat) begin
        case (phase)
          AWAIT_L: begin
            if (!s_tlast) begin
              cap_l <= sample;
              phase <= AWAIT_R;
            end
          end
          AWAIT_R: begin
            if (s_tlast) begin
              cap_r <= sample;
              phase <= DONE;
            end else begin
              cap_l <= sample;
            end
          end
          default: ;
        endcase
      end
      if (underrun) begin
        cap_l <= sub_l;
        cap_r <= sub_r;
      end
    end
  end

  // Saturating underrun counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mixer_frame_scheduler.sv
// rtl/mixer_frame_scheduler.sv - frame-paced two-channel stereo mixer scheduler (MIXER_SCHED_HOLD_LAST_EN)
module mixer_frame_scheduler
  import mixer_sched_pkg::*;
#(
  parameter int AUDIO_WIDTH    = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  frame_tick,
  input  logic [1:0]            ch_en,
  input  logic                  CH_1_S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] CH_1_S_AXIS_TDATA,
  input  logic                  CH_1_S_AXIS_TLAST,
  output logic                  CH_1_S_AXIS_TREADY,
  input  logic                  CH_2_S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] CH_2_S_AXIS_TDATA,
  input  logic                  CH_2_S_AXIS_TLAST,
  output logic                  CH_2_S_AXIS_TREADY,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_1,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_2,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  sched_state_t           state;
  sched_state_t           state_next;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   start;
  logic                   fetch;
  logic                   close;
  logic                   ch1_done_next;
  logic                   ch2_done_next;
  logic [AUDIO_WIDTH-1:0] ch1_left;
  logic [AUDIO_WIDTH-1:0] ch1_right;
  logic [AUDIO_WIDTH-1:0] ch2_left;
  logic [AUDIO_WIDTH-1:0] ch2_right;
  logic [31:0]            sum_l;
  logic [31:0]            sum_r;
  logic                   unused_sum;
  logic [AUDIO_WIDTH-1:0] mix_l;
  logic [AUDIO_WIDTH-1:0] mix_r;

  assign start = (state == IDLE) && frame_tick;
  assign fetch = (state == FETCH);
  // Leave FETCH as soon as every enabled channel has its pair, or on timeout.
  assign close = fetch && ((ch1_done_next && ch2_done_next) || (timer == '0));
  assign busy  = (state != IDLE);

  mixer_sched_chan_rx #(
    .AUDIO_WIDTH(AUDIO_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ch1 (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .start       (start),
    .en_in       (ch_en[0]),
    .fetch       (fetch),
    .close       (close),
    .s_tvalid    (CH_1_S_AXIS_TVALID),
    .s_tdata     (CH_1_S_AXIS_TDATA),
    .s_tlast     (CH_1_S_AXIS_TLAST),
    .s_tready    (CH_1_S_AXIS_TREADY),
    .done_next   (ch1_done_next),
    .left        (ch1_left),
    .right       (ch1_right),
    .underrun_cnt(underrun_cnt_1)
  );

  mixer_sched_chan_rx #(
    .AUDIO_WIDTH(AUDIO_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ch2 (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .start       (start),
    .en_in       (ch_en[1]),
    .fetch       (fetch),
    .close       (close),
    .s_tvalid    (CH_2_S_AXIS_TVALID),
    .s_tdata     (CH_2_S_AXIS_TDATA),
    .s_tlast     (CH_2_S_AXIS_TLAST),
    .s_tready    (CH_2_S_AXIS_TREADY),
    .done_next   (ch2_done_next),
    .left        (ch2_left),
    .right       (ch2_right),
    .underrun_cnt(underrun_cnt_2)
  );

  assign sum_l      = sat_add(32'($signed(ch1_left)), 32'($signed(ch2_left)), AUDIO_WIDTH);
  assign sum_r      = sat_add(32'($signed(ch1_right)), 32'($signed(ch2_right)), AUDIO_WIDTH);
  assign unused_sum = ^{sum_l, sum_r};

  // State register; reset abandons any frame in progress.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and master stream outputs; TDATA is held while a beat waits.
  always_comb begin
    state_next    = state;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) state_next = FETCH;
      end
      FETCH: begin
        if (close) state_next = MIX;
      end
      MIX: begin
        state_next = SEND_L;
      end
      SEND_L: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA[DATA_WIDTH-1 -: AUDIO_WIDTH] = mix_l;
        if (M_AXIS_TREADY) state_next = SEND_R;
      end
      SEND_R: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        M_AXIS_TDATA[DATA_WIDTH-1 -: AUDIO_WIDTH] = mix_r;
        if (M_AXIS_TREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FETCH window timer, loaded on the accepted tick.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      timer <= '0;
    end else if (start) begin
      timer <= TIMER_LOAD;
    end else if (fetch && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

  // Register the clamped mix once per frame.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mix_l <= '0;
      mix_r <= '0;
    end else if (state == MIX) begin
      mix_l <= sum_l[AUDIO_WIDTH-1:0];
      mix_r <= sum_r[AUDIO_WIDTH-1:0];
    end
  end

  // Any tick that arrives while a frame is in flight is dropped and flagged.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      overrun <= 1'b0;
    end else begin
      overrun <= frame_tick && (state != IDLE);
    end
  end

endmodule

// File: doc/mixer_frame_scheduler.md
# mixer_frame_scheduler

Frame-paced controller in front of the stereo mixer output. On each codec sample tick it collects one left/right pair from each of two AXI-Stream channel inputs, substitutes silence for late or disabled channels, and forms a saturated sum. It then emits the mixed pair on the codec-facing AXI-Stream master as left then right. It replaces free-running, ready-driven pacing with a deterministic per-frame schedule and reports underruns and overruns.

## Interface
- AUDIO_WIDTH, 24: sample width, MSB-aligned in TDATA (TDATA[DATA_WIDTH-1 -: AUDIO_WIDTH]).
- DATA_WIDTH, 32: AXI-Stream TDATA width; unused LSBs are ignored on input and driven 0 on output.
- TIMEOUT_CYCLES, 256: FETCH window length in ACLK cycles.
- CNT_WIDTH, 16: underrun counter width.
- ACLK  in  1  single clock for all logic and all streams.
- ARESETN  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per codec sample period.
- ch_en  in  2  bit0 = channel 1 enable, bit1 = channel 2 enable; sampled on the tick that starts a frame.
- CH_1_S_AXIS_TVALID / TDATA / TLAST  in  1 / DATA_WIDTH / 1: channel 1 stream; TLAST=0 marks left, TLAST=1 marks right.
- CH_1_S_AXIS_TREADY  out  1
- CH_2_S_AXIS_TVALID / TDATA / TLAST / TREADY: same as channel 1.
- M_AXIS_TREADY  in  1
- M_AXIS_TVALID / TDATA / TLAST  out  1 / DATA_WIDTH / 1
- underrun_cnt_1, underrun_cnt_2  out  CNT_WIDTH  saturating per-channel underrun counts.
- overrun  out  1  one-cycle pulse on a dropped tick.
- busy  out  1  high when state != IDLE.

## Operation
- FSM states: IDLE, FETCH, MIX, SEND_L, SEND_R.
- IDLE: on frame_tick, latch ch_en, clear per-channel flags, load timer = TIMEOUT_CYCLES-1, go to FETCH.
- FETCH: each channel's TREADY = enabled && !pair_done, combinational from registered state and flags.
  - Beat with TLAST=0 while awaiting left: capture left.
  - Beat with TLAST=1 while awaiting left (misaligned): accept and discard; keep awaiting left.
  - Beat with TLAST=1 after left: capture right and set pair_done.
  - Beat with TLAST=0 after left: replace left and keep awaiting right.
  - Exit to MIX on the edge where the last enabled channel completes, or when the timer reaches 0.
  - A disabled channel contributes 0 and is never counted as an underrun.
- Timeout: each enabled channel without pair_done increments its counter (saturating at all-ones) and contributes the substitute pair; a partial left is discarded.
- MIX: sign-extend both channels to AUDIO_WIDTH+1 bits and add. Clamp to [-2^(AUDIO_WIDTH-1), 2^(AUDIO_WIDTH-1)-1] and register the left and right results.
- SEND_L: TVALID=1, TDATA=left, TLAST=0; on TREADY go to SEND_R.
- SEND_R: TVALID=1, TDATA=right, TLAST=1; on TREADY go to IDLE.
- A frame_tick outside IDLE is dropped and pulses overrun for one cycle. A tick in the same cycle as the SEND_R handshake is also dropped.

## Timing
- Reset values: all TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, counters 0, overrun=0, busy=0, state IDLE. Captured samples and last-good samples are cleared to 0.
- Reset asserted mid-frame: outputs drop to reset values immediately (asynchronously), and the frame is abandoned.
- Best-case latency, with data valid and M_AXIS_TREADY=1:
  - tick at cycle t; FETCH at t+1 (left accepted); right accepted at t+2.
  - MIX at t+3.
  - Left beat at t+4, right beat at t+5.
  - IDLE at t+6.
- Timeout path: MIX occurs TIMEOUT_CYCLES cycles after entering FETCH.
- TVALID, once asserted, is held stable with TDATA and TLAST until the handshake completes.
- Minimum tick spacing is 6 cycles; shorter spacing produces overrun.

## Configuration
- MIXER_SCHED_HOLD_LAST_EN defined: the underrun substitute is the channel's last successfully received pair, updated on each completed fetch.
- MIXER_SCHED_HOLD_LAST_EN undefined: the substitute is 0/0, and no last-good registers are built.

## Structure
- Package mixer_sched_pkg contains:
  - state enum (IDLE, FETCH, MIX, SEND_L, SEND_R);
  - per-channel fetch-phase enum (AWAIT_L, AWAIT_R, DONE);
  - function sat_add(a, b, width).
- Sub-module mixer_sched_chan_rx, instantiated twice: per-channel TREADY, left/right capture, realignment, last-good hold, and underrun counter.
- Top-level contains the FSM, timer, MIX stage and master port.

## Test plan
- Clean frame: ch1 L=0x000100/R=0x000200, ch2 L=0x000010/R=0x000020, tick, TREADY=1 -> TDATA 0x00011000 (TLAST=0) at t+4, then 0x00022000 (TLAST=1) at t+5.
- Saturation: ch1 L=0x7FFFF0, ch2 L=0x000100 -> left 0x7FFFFF00. Ch1 R=0x800000, ch2 R=0xFFFFFF -> right 0x80000000.
- Underrun: ch2 silent, TIMEOUT_CYCLES=16 -> MIX 16 cycles after FETCH entry; underrun_cnt_2=1, ch1 passes unmixed. With the macro, ch2 repeats its previous pair.
- Misalignment: ch1 sends TLAST=1 first, then L=5, R=6 -> stray beat discarded; output reflects 5/6 plus ch2.
- Overrun and backpressure: hold M_AXIS_TREADY=0 for 10 cycles, tick again during SEND_L -> overrun pulse, TDATA stable; one frame delivered.
- Reset in SEND_L: ARESETN low -> TVALID=0 the same cycle; after release, the next tick yields a normal frame with counters at 0.
